seq_acc_alu: RTL and testbench
==============================

# seq_acc_alu

Parametrised accumulator ALU: a 2W-bit accumulator is updated each accepted operation from a W-bit datapath operand under a 4-bit opcode. Single-cycle logic and add/sub ops are combined with an iterative multi-cycle multiplier and divider behind a valid/ready handshake. Carry, zero and divide-by-zero flags are registered. It is the width-generic, flow-controlled core that sits between the instruction sequencer and the result bus.

## Interface
- W, 16, operand width; accumulator is 2W; minimum 4.
- clk  in  1  clock, rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select, sampled on accept.
- dp_input  in  W  operand B, sampled on accept.
- dp_output  out  2W  accumulator value.
- busy  out  1  multi-cycle MUL/DIV in progress; equals !op_ready.
- carry_flag  out  1  carry / borrow status.
- zero_flag  out  1  last written accumulator value was zero.
- dz_flag  out  1  last DIV had B == 0.

## Operation
- Accept: op_valid && op_ready at a rising edge. A = acc[W-1:0], B = dp_input.
- Opcodes:
  - 0 NOP: hold. 1 CLR: acc = 0. 2 SET: acc = all ones.
  - 3 DIV: unsigned A/B, multi-cycle.
  - 4 SUB: A-B. 5 SBB: A-B-carry_flag. 6 ADD: A+B. 7 ADC: A+B+carry_flag.
  - 8 MUL: unsigned A*B, full 2W-bit result, multi-cycle.
  - 9 AND, 10 OR, 12 XOR: A op B. 11 NOT: ~B.
  - 13–15: reserved; accepted, no state or flag change.
- Width rules:
  - W-bit results (ops 4–7, 9–12, DIV quotient) go into acc[W-1:0]; acc[2W-1:W] is cleared, except DIV under the config macro.
- carry_flag:
  - Written only by ops 4–7: carry-out for ADD/ADC, borrow-out for SUB/SBB.
  - Held otherwise.
- zero_flag: written by every op that writes acc (1–12); set when the new 2W-bit acc == 0.
- dz_flag:
  - Written only on DIV completion: 1 if B == 0, else 0.
  - DIV by zero still runs the full iteration and yields quotient all ones, remainder A.
- State machine IDLE → RUN → IDLE:
  - IDLE: op_ready = 1; an accept of MUL or DIV loads the operands and a counter = W, then moves to RUN. Other ops complete at the accept edge.
  - RUN: one shift-add / restoring-subtract step per edge; counter decrements. At the edge where counter == 1, acc and flags are written and the FSM returns to IDLE.
  - op_valid during RUN is ignored, with no queuing. The requester holds op_valid until it sees op_ready.

## Timing
- Reset values: dp_output = 0, carry/zero/dz flags = 0, busy = 0, op_ready = 1, FSM = IDLE, counter = 0.
- Single-cycle ops: result visible on dp_output after the accept edge; back-to-back accepts every cycle.
- MUL/DIV:
  - Accept at edge E0; busy = 1 from after E0 until EW.
  - Result and flags are written at edge EW, W edges after E0.
  - op_ready = 1 after EW; the next accept is possible at EW+1.
- Reset mid-RUN: the operation is aborted immediately; all state returns to reset values and no partial result is written.
- Flags and acc update on the same edge; there are no combinational paths from inputs to outputs except op_ready/busy from the FSM.

## Configuration
- ALU_DIVREM_EN defined: DIV writes the remainder into acc[2W-1:W] and the quotient into acc[W-1:0].
- ALU_DIVREM_EN undefined: acc[2W-1:W] = 0 after DIV, and the remainder logic is not built.

## Structure
- Package alu_pkg holds the opcode localparams (OP_NOP … OP_XOR), the FSM state encoding and the opcode width constant.
- Sub-module seq_muldiv_core, parametrised by W:
  - Iterative shift-add multiplier and restoring divider sharing one W+1-bit adder.
  - Ports: start, is_div, a, b; returns done, product/quotient, remainder.
- The top level holds the accumulator, flags, handshake and single-cycle ops.

## Test plan
All scenarios use W = 16.
- Reset: after rstb release, dp_output = 0x00000000, all flags 0, op_ready = 1.
- Carry: SET, ADD 0x0001 → acc 0x00000000, carry = 1, zero = 1; then ADC 0x0005 → 0x00000006, carry = 0.
- Borrow: CLR, SUB 0x0001 → 0x0000FFFF, carry = 1; then SBB 0x0000 → 0x0000FFFE, carry = 0.
- MUL: CLR, ADD 0x1234, MUL 0x0100 with op_valid held high → op_ready low for 16 cycles, acc 0x00123400, no extra op accepted during RUN.
- DIV: CLR, ADD 100, DIV 7 → 0x0002000E with ALU_DIVREM_EN, 0x0000000E without; dz = 0. Then CLR, ADD 5, DIV 0 → low half 0xFFFF, dz = 1.
- Abort: assert rstb low at the 8th RUN cycle of a MUL → dp_output 0, op_ready = 1 after release; a following ADD 0x0003 → 0x00000003.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the seq_acc_alu accumulator ALU: opcode encodings,
// opcode width and FSM state encoding.
package alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'd0;
    localparam logic [OPW-1:0] OP_CLR = 4'd1;
    localparam logic [OPW-1:0] OP_SET = 4'd2;
    localparam logic [OPW-1:0] OP_DIV = 4'd3;
    localparam logic [OPW-1:0] OP_SUB = 4'd4;
    localparam logic [OPW-1:0] OP_SBB = 4'd5;
    localparam logic [OPW-1:0] OP_ADD = 4'd6;
    localparam logic [OPW-1:0] OP_ADC = 4'd7;
    localparam logic [OPW-1:0] OP_MUL = 4'd8;
    localparam logic [OPW-1:0] OP_AND = 4'd9;
    localparam logic [OPW-1:0] OP_OR  = 4'd10;
    localparam logic [OPW-1:0] OP_NOT = 4'd11;
    localparam logic [OPW-1:0] OP_XOR = 4'd12;

    typedef enum logic [0:0] {StIdle, StRun} alu_state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one W+1-bit adder.
// ALU_DIVREM_EN builds the remainder output; otherwise remainder reads as zero.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           start,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod_quo,
    output logic [W-1:0]   remainder
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;

    logic [W:0]    add_x, add_y;
    logic          add_ci;
    logic [W+1:0]  add_sum;
    logic          cout;
    logic [W-1:0]  hi_n, lo_n;

    // hi holds partial product / partial remainder; lo holds multiplier / quotient bits.
    always_comb begin
        if (div_q) begin
            add_x  = {hi_q, lo_q[W-1]};
            add_y  = ~{1'b0, b_q};
            add_ci = 1'b1;
        end else begin
            add_x  = {1'b0, hi_q};
            add_y  = lo_q[0] ? {1'b0, b_q} : '0;
            add_ci = 1'b0;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(W + 1){1'b0}}, add_ci};
        cout    = add_sum[W+1];
        if (div_q) begin
            hi_n = cout ? add_sum[W-1:0] : add_x[W-1:0];
            lo_n = {lo_q[W-2:0], cout};
        end else begin
            hi_n = add_sum[W:1];
            lo_n = {add_sum[0], lo_q[W-1:1]};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start) begin
            cnt_d = CW'(W);
            div_d = is_div;
            b_d   = b;
            hi_d  = '0;
            lo_d  = a;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = hi_n;
            lo_d  = lo_n;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Results are the outcome of the final step, written by the top on the same edge.
    assign done     = (cnt_q == CW'(1));
    assign prod_quo = div_q ? {{W{1'b0}}, lo_n} : {hi_n, lo_n};

`ifdef ALU_DIVREM_EN
    assign remainder = hi_n;
`else
    assign remainder = '0;
`endif

endmodule

// File: rtl/seq_acc_alu.sv
// Accumulator ALU top: 2W-bit accumulator, flags, valid/ready handshake and single-cycle ops.
// ALU_DIVREM_EN places the DIV remainder into the accumulator upper half.
module seq_acc_alu
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [W-1:0]   dp_input,
    output logic [2*W-1:0] dp_output,
    output logic           busy,
    output logic           carry_flag,
    output logic           zero_flag,
    output logic           dz_flag
);

    alu_state_e     state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;
    logic           dz_q, dz_d;
    logic           div_q, div_d;
    logic           bz_q, bz_d;

    logic           accept, start, wr_acc;
    logic [W-1:0]   a_op;
    logic [W:0]     add_res, sub_res;
    logic           md_done;
    logic [2*W-1:0] md_prod_quo;
    logic [W-1:0]   md_rem;

    assign accept = op_valid && op_ready;
    assign start  = accept && ((opcode == OP_MUL) || (opcode == OP_DIV));
    assign a_op   = acc_q[W-1:0];

    seq_muldiv_core #(
        .W (W)
    ) u_muldiv (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .is_div    (opcode == OP_DIV),
        .a         (a_op),
        .b         (dp_input),
        .done      (md_done),
        .prod_quo  (md_prod_quo),
        .remainder (md_rem)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (md_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_ready = (state_q == StIdle);
        busy     = !op_ready;
    end

    always_comb begin
        add_res = {1'b0, a_op} + {1'b0, dp_input}
                + {{W{1'b0}}, (opcode == OP_ADC) & carry_q};
        sub_res = {1'b0, a_op} - {1'b0, dp_input}
                - {{W{1'b0}}, (opcode == OP_SBB) & carry_q};
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
        div_d   = div_q;
        bz_d    = bz_q;
        wr_acc  = 1'b0;
        if (accept) begin
            case (opcode)
                OP_CLR: begin acc_d = '0; wr_acc = 1'b1; end
                OP_SET: begin acc_d = '1; wr_acc = 1'b1; end
                OP_SUB, OP_SBB: begin
                    acc_d   = {{W{1'b0}}, sub_res[W-1:0]};
                    carry_d = sub_res[W];
                    wr_acc  = 1'b1;
                end
                OP_ADD, OP_ADC: begin
                    acc_d   = {{W{1'b0}}, add_res[W-1:0]};
                    carry_d = add_res[W];
                    wr_acc  = 1'b1;
                end
                OP_AND: begin acc_d = {{W{1'b0}}, a_op & dp_input}; wr_acc = 1'b1; end
                OP_OR:  begin acc_d = {{W{1'b0}}, a_op | dp_input}; wr_acc = 1'b1; end
                OP_XOR: begin acc_d = {{W{1'b0}}, a_op ^ dp_input}; wr_acc = 1'b1; end
                OP_NOT: begin acc_d = {{W{1'b0}}, ~dp_input}; wr_acc = 1'b1; end
                OP_MUL, OP_DIV: begin
                    div_d = (opcode == OP_DIV);
                    bz_d  = (dp_input == '0);
                end
                default: ;
            endcase
        end
        if ((state_q == StRun) && md_done) begin
            acc_d  = div_q ? {md_rem, md_prod_quo[W-1:0]} : md_prod_quo;
            dz_d   = div_q ? bz_q : dz_q;
            wr_acc = 1'b1;
        end
        if (wr_acc) begin
            zero_d = (acc_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            bz_q    <= bz_d;
        end
    end

    assign dp_output  = acc_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign dz_flag    = dz_q;

endmodule

// File: tb/tb_seq_acc_alu.sv
// Directed, table-driven bench for seq_acc_alu at W = 16, plus hand sequences for
// MUL handshake timing and reset abort.
module tb_seq_acc_alu;

    localparam int unsigned W = 16;

`ifdef ALU_DIVREM_EN
    localparam logic [31:0] DIV7_EXP = 32'h0002000E;
    localparam logic [31:0] DIV0_EXP = 32'h0005FFFF;
`else
    localparam logic [31:0] DIV7_EXP = 32'h0000000E;
    localparam logic [31:0] DIV0_EXP = 32'h0000FFFF;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [15:0] din;
        logic [31:0] acc;
        logic        c;
        logic        z;
        logic        dz;
    } vec_t;

    logic           clk = 1'b0;
    logic           rstb = 1'b0;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [3:0]     opcode = 4'd0;
    logic [W-1:0]   dp_input = '0;
    logic [2*W-1:0] dp_output;
    logic           busy;
    logic           carry_flag;
    logic           zero_flag;
    logic           dz_flag;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_acc_alu #(
        .W (W)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .dp_input   (dp_input),
        .dp_output  (dp_output),
        .busy       (busy),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .dz_flag    (dz_flag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int i = 0;
        while (op_ready !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check({name, "_ready"}, {63'b0, op_ready}, 64'd1);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [15:0] din, input string name);
        wait_ready({name, "_pre"});
        opcode   = op;
        dp_input = din;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        wait_ready({name, "_post"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        rstb = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("rst_acc", {32'b0, dp_output}, 64'h0);
        check("rst_carry", {63'b0, carry_flag}, 64'd0);
        check("rst_zero", {63'b0, zero_flag}, 64'd0);
        check("rst_dz", {63'b0, dz_flag}, 64'd0);
        check("rst_ready", {63'b0, op_ready}, 64'd1);
        check("rst_busy", {63'b0, busy}, 64'd0);

        vecs.push_back('{4'd2,  16'h0000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}); // SET
        vecs.push_back('{4'd6,  16'h0001, 32'h00000000, 1'b1, 1'b1, 1'b0}); // ADD
        vecs.push_back('{4'd7,  16'h0005, 32'h00000006, 1'b0, 1'b0, 1'b0}); // ADC
        vecs.push_back('{4'd1,  16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0}); // CLR
        vecs.push_back('{4'd4,  16'h0001, 32'h0000FFFF, 1'b1, 1'b0, 1'b0}); // SUB
        vecs.push_back('{4'd5,  16'h0000, 32'h0000FFFE, 1'b0, 1'b0, 1'b0}); // SBB
        vecs.push_back('{4'd9,  16'h0F0F, 32'h00000F0E, 1'b0, 1'b0, 1'b0}); // AND
        vecs.push_back('{4'd10, 16'hF000, 32'h0000FF0E, 1'b0, 1'b0, 1'b0}); // OR
        vecs.push_back('{4'd12, 16'h00FF, 32'h0000FFF1, 1'b0, 1'b0, 1'b0}); // XOR
        vecs.push_back('{4'd11, 16'h1234, 32'h0000EDCB, 1'b0, 1'b0, 1'b0}); // NOT
        vecs.push_back('{4'd13, 16'hABCD, 32'h0000EDCB, 1'b0, 1'b0, 1'b0}); // reserved
        vecs.push_back('{4'd0,  16'h0001, 32'h0000EDCB, 1'b0, 1'b0, 1'b0}); // NOP
        vecs.push_back('{4'd1,  16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0}); // CLR
        vecs.push_back('{4'd6,  16'h1234, 32'h00001234, 1'b0, 1'b0, 1'b0}); // ADD
        vecs.push_back('{4'd8,  16'h0100, 32'h00123400, 1'b0, 1'b0, 1'b0}); // MUL
        vecs.push_back('{4'd1,  16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0}); // CLR
        vecs.push_back('{4'd6,  16'd100,  32'h00000064, 1'b0, 1'b0, 1'b0}); // ADD
        vecs.push_back('{4'd3,  16'd7,    DIV7_EXP,     1'b0, 1'b0, 1'b0}); // DIV
        vecs.push_back('{4'd1,  16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0}); // CLR
        vecs.push_back('{4'd6,  16'd5,    32'h00000005, 1'b0, 1'b0, 1'b0}); // ADD
        vecs.push_back('{4'd3,  16'd0,    DIV0_EXP,     1'b0, 1'b0, 1'b1}); // DIV by 0
        vecs.push_back('{4'd6,  16'h0001, 32'h00000000, 1'b1, 1'b1, 1'b1}); // ADD wraps
        vecs.push_back('{4'd15, 16'h5555, 32'h00000000, 1'b1, 1'b1, 1'b1}); // reserved
        vecs.push_back('{4'd4,  16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b1}); // SUB 0

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].op, vecs[i].din, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_acc", i), {32'b0, dp_output}, {32'b0, vecs[i].acc});
            check($sformatf("vec%0d_carry", i), {63'b0, carry_flag}, {63'b0, vecs[i].c});
            check($sformatf("vec%0d_zero", i), {63'b0, zero_flag}, {63'b0, vecs[i].z});
            check($sformatf("vec%0d_dz", i), {63'b0, dz_flag}, {63'b0, vecs[i].dz});
        end

        // MUL with op_valid held: busy window length and no extra accept during RUN.
        do_op(4'd1, 16'h0000, "mh_clr");
        do_op(4'd6, 16'h1234, "mh_add");
        opcode   = 4'd8;
        dp_input = 16'h0100;
        op_valid = 1'b1;
        @(negedge clk);
        opcode   = 4'd6;
        dp_input = 16'hFFFF;
        cnt = 0;
        while (op_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        check("mh_busy_cycles", 64'(cnt), 64'd16);
        check("mh_acc", {32'b0, dp_output}, 64'h00123400);
        check("mh_carry", {63'b0, carry_flag}, 64'd0);

        // Reset during the 8th RUN cycle of a MUL.
        do_op(4'd1, 16'h0000, "ab_clr");
        do_op(4'd4, 16'h0001, "ab_sub");
        check("ab_pre_carry", {63'b0, carry_flag}, 64'd1);
        opcode   = 4'd8;
        dp_input = 16'h0100;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("ab_busy_before", {63'b0, busy}, 64'd1);
        rstb = 1'b0;
        #1;
        check("ab_rst_acc", {32'b0, dp_output}, 64'h0);
        check("ab_rst_ready", {63'b0, op_ready}, 64'd1);
        @(negedge clk);
        rstb = 1'b1;
        repeat (20) @(negedge clk);
        check("ab_acc", {32'b0, dp_output}, 64'h0);
        check("ab_ready", {63'b0, op_ready}, 64'd1);
        check("ab_carry", {63'b0, carry_flag}, 64'd0);
        check("ab_dz", {63'b0, dz_flag}, 64'd0);
        check("ab_zero", {63'b0, zero_flag}, 64'd0);
        do_op(4'd6, 16'h0003, "ab_add");
        check("ab_add_acc", {32'b0, dp_output}, 64'h00000003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
